// File: rtl/function_unit_mc_pkg.sv
// function_unit_pkg: shared definitions for the multi-cycle function unit.
//   - FS_* : function-select encodings (single-cycle set plus MUL/DIVU/REMU/ASR)
//   - state_t : control state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   - is_multicycle() : true for ops that run through the iterative datapath
package function_unit_pkg;

   localparam logic [4:0] FS_MOV  = 5'b00000;
   localparam logic [4:0] FS_ADD  = 5'b00010;
   localparam logic [4:0] FS_SUB  = 5'b00101;
   localparam logic [4:0] FS_JML  = 5'b00111;
   localparam logic [4:0] FS_AND  = 5'b01000;
   localparam logic [4:0] FS_OR   = 5'b01010;
   localparam logic [4:0] FS_XOR  = 5'b01100;
   localparam logic [4:0] FS_NOT  = 5'b01110;
   localparam logic [4:0] FS_LSL  = 5'b10100;
   localparam logic [4:0] FS_LSR  = 5'b11000;
   localparam logic [4:0] FS_MUL  = 5'b10001;
   localparam logic [4:0] FS_DIVU = 5'b10010;
   localparam logic [4:0] FS_REMU = 5'b10011;
   localparam logic [4:0] FS_ASR  = 5'b11100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(input logic [4:0] fs);
      return (fs == FS_MUL) || (fs == FS_DIVU) || (fs == FS_REMU);
   endfunction

endpackage

// File: rtl/function_unit_mc_iter_muldiv.sv
// iter_muldiv: iterative shift-add multiplier / restoring divider.
//   clk, rst   : clock, asynchronous active-high reset (clears busy/counter)
//   start      : load operands and begin WIDTH iterations
//   op         : 0 = multiply, 1 = divide
//   a, b       : operands (multiplicand/dividend a, multiplier/divisor b)
//   done       : high during the final iteration cycle; results below are
//                valid (combinationally) in that cycle
//   prod_lo/hi : low/high halves of a*b
//   quot, rem  : a/b and a%b
module iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH);

   logic             busy;
   logic [CW-1:0]    cnt;
   logic             op_p1;
   logic [WIDTH-1:0] d_p1;
   logic [WIDTH-1:0] hi_p1;
   logic [WIDTH-1:0] lo_p1;

   // Multiply: {hi,lo} holds partial product above the remaining multiplier bits.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_neg;
   logic [WIDTH-1:0] div_hi, div_lo;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;

   always_comb begin
      mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, d_p1} : '0);
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], lo_p1[WIDTH-1:1]};
      div_shift = {hi_p1, lo_p1[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, d_p1};
      div_neg   = div_diff[WIDTH+1];
      // A negative trial means restore; the shifted value is then < divisor.
      div_hi    = div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      div_lo    = {lo_p1[WIDTH-2:0], ~div_neg};
      nxt_hi    = op_p1 ? div_hi : mul_hi;
      nxt_lo    = op_p1 ? div_lo : mul_lo;
   end

   assign done    = busy && (cnt == '0);
   assign prod_lo = nxt_lo;
   assign prod_hi = nxt_hi;
   assign quot    = nxt_lo;
   assign rem     = nxt_hi;

   // Iteration control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(WIDTH - 1);
      end else if (busy) begin
         if (cnt == '0) busy <= 1'b0;
         else           cnt  <= cnt - CW'(1);
      end
   end

   // Iteration datapath
   always_ff @(posedge clk) begin
      if (start) begin
         op_p1 <= op;
         d_p1  <= op ? b : a;
         hi_p1 <= '0;
         lo_p1 <= op ? a : b;
      end else if (busy) begin
         hi_p1 <= nxt_hi;
         lo_p1 <= nxt_lo;
      end
   end

endmodule

// File: rtl/function_unit_mc.sv
// function_unit_mc: multi-cycle execute-stage function unit with
// valid/ready handshakes on operands and results.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (A, B, FS, SH captured on accept)
//   out_valid / out_ready: result handshake (F, Z, C, V, N, err held while waiting)
//   A, B                 : operands, FS : function select, SH : shift amount
//   F                    : result, Z/C/V/N : flags, err : undefined FS
module function_unit_mc
   import function_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       FS,
   input  logic [SHW-1:0]   SH,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             N,
   output logic             err
);

   state_t state, state_nxt;

   logic accept, div_by_zero, go_busy;
   logic md_done;
   logic [WIDTH-1:0] md_prod_lo, md_prod_hi, md_quot, md_rem;
   logic [4:0] fs_p1;

   assign accept      = (state == ST_IDLE) && in_valid;
   // Divide by zero has a fixed answer, so it skips the iterative path.
   assign div_by_zero = ((FS == FS_DIVU) || (FS == FS_REMU)) && (B == '0);
   assign go_busy     = is_multicycle(FS) && !div_by_zero;

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && go_busy),
      .op      (FS != FS_MUL),
      .a       (A),
      .b       (B),
      .done    (md_done),
      .prod_lo (md_prod_lo),
      .prod_hi (md_prod_hi),
      .quot    (md_quot),
      .rem     (md_rem)
   );

   // Stage p0: single-cycle ops on the live operands
   logic [WIDTH:0]          add_ext, sub_ext, lsl_ext, lsr_ext;
   logic signed [WIDTH:0]   asr_ext;
   logic [WIDTH-1:0]        f_p0;
   logic                    c_p0, v_p0, err_p0;

   always_comb begin
      add_ext = {1'b0, A} + {1'b0, B};
      sub_ext = {1'b0, A} - {1'b0, B};
      // One guard bit on the outgoing side catches the last bit shifted out.
      lsl_ext = {1'b0, A} << SH;
      lsr_ext = {A, 1'b0} >> SH;
      asr_ext = $signed({A, 1'b0}) >>> SH;
      f_p0    = '0;
      c_p0    = 1'b0;
      v_p0    = 1'b0;
      err_p0  = 1'b0;
      case (FS)
         FS_MOV, FS_JML: f_p0 = A;
         FS_ADD: begin
            f_p0 = add_ext[WIDTH-1:0];
            c_p0 = add_ext[WIDTH];
            v_p0 = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
         end
         FS_SUB: begin
            f_p0 = sub_ext[WIDTH-1:0];
            c_p0 = sub_ext[WIDTH];
            v_p0 = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] == B[WIDTH-1]);
         end
         FS_AND: f_p0 = A & B;
         FS_OR:  f_p0 = A | B;
         FS_XOR: f_p0 = A ^ B;
         FS_NOT: f_p0 = ~A;
         FS_LSL: begin
            f_p0 = lsl_ext[WIDTH-1:0];
            c_p0 = lsl_ext[WIDTH];
         end
         FS_LSR: begin
            f_p0 = lsr_ext[WIDTH:1];
            c_p0 = lsr_ext[0];
         end
         FS_ASR: begin
            f_p0 = asr_ext[WIDTH:1];
            c_p0 = asr_ext[0];
         end
         FS_MUL: f_p0 = '0;
         // Only reached with B == 0; the nonzero case is iterative.
         FS_DIVU: begin
            f_p0 = '1;
            v_p0 = 1'b1;
         end
         FS_REMU: begin
            f_p0 = A;
            v_p0 = 1'b1;
         end
         default: err_p0 = 1'b1;
      endcase
   end

   logic [WIDTH-1:0] f_mc;
   logic             c_mc;

   always_comb begin
      f_mc = md_rem;
      if (fs_p1 == FS_MUL)       f_mc = md_prod_lo;
      else if (fs_p1 == FS_DIVU) f_mc = md_quot;
      c_mc = (fs_p1 == FS_MUL) && (md_prod_hi != '0);
   end

   // Stage p1: registered result and flags
   always_ff @(posedge clk) begin
      if (accept) fs_p1 <= FS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         F   <= '0;
         Z   <= 1'b0;
         C   <= 1'b0;
         V   <= 1'b0;
         N   <= 1'b0;
         err <= 1'b0;
      end else if (accept && !go_busy) begin
         F   <= f_p0;
         Z   <= (f_p0 == '0);
         C   <= c_p0;
         V   <= v_p0;
         N   <= f_p0[WIDTH-1];
         err <= err_p0;
      end else if ((state == ST_BUSY) && md_done) begin
         F   <= f_mc;
         Z   <= (f_mc == '0);
         C   <= c_mc;
         V   <= 1'b0;
         N   <= f_mc[WIDTH-1];
         err <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = go_busy ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

endmodule

// File: tb/tb_function_unit_mc.sv
module tb_function_unit_mc;
   import function_unit_pkg::*;

   localparam int W   = 32;
   localparam int SHW = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]   A, B, F;
   logic [4:0]     FS;
   logic [SHW-1:0] SH;
   logic           Z, C, V, N, err;

   function_unit_mc #(.WIDTH(W), .SHW(SHW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .FS(FS), .SH(SH), .out_valid(out_valid),
      .out_ready(out_ready), .F(F), .Z(Z), .C(C), .V(V), .N(N), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string        name;
      logic [W-1:0] f;
      logic         z, c, v, n, e;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   acc_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: checks each result once, on the first cycle it is presented.
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid !== 1'b1) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got F=%0h with no result pending", F);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_F"},   F,   e.f);
               chk({e.name, "_ZCVN"}, {Z, C, V, N}, {e.z, e.c, e.v, e.n});
               chk({e.name, "_err"}, err, e.e);
               chk({e.name, "_lat"}, cyc - acc_cyc + 1, e.lat);
            end
         end
      end
   end

   task automatic expect_r(input string nm, input logic [W-1:0] f,
                           input logic z, c, v, n, e, input int lat);
      exp_t x;
      x.name = nm; x.f = f; x.z = z; x.c = c; x.v = v; x.n = n; x.e = e; x.lat = lat;
      sb.push_back(x);
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic issue(input logic [4:0] fs, input logic [W-1:0] a, b,
                        input logic [SHW-1:0] sh);
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
      end
      FS = fs; A = a; B = b; SH = sh; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      // Scramble operands to show they were captured at acceptance.
      A = ~a; B = b ^ 32'h5A5A_A5A5; SH = ~sh; FS = 5'b11111;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(in_ready === 1'b1 && out_valid === 1'b0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_idle_timeout: in_ready=%b out_valid=%b, required 1/0",
                  in_ready, out_valid);
      end
   endtask

   task automatic run(input string nm, input logic [4:0] fs, input logic [W-1:0] a, b,
                      input logic [SHW-1:0] sh, input logic [W-1:0] f,
                      input logic z, c, v, n, e, input int lat);
      expect_r(nm, f, z, c, v, n, e, lat);
      issue(fs, a, b, sh);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt_v;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; FS = '0; SH = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready",  in_ready,  1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_F",         F,         '0);
      chk("reset_flags",     {Z, C, V, N, err}, 5'b0);

      //   name          FS       A             B             SH  F             Z C V N e lat
      run("add_ovf",  FS_ADD,  32'h7FFF_FFFF, 32'h1,        0, 32'h8000_0000, 0,0,1,1,0, 1);
      run("sub_brw",  FS_SUB,  32'h0,         32'h1,        0, 32'hFFFF_FFFF, 0,1,0,1,0, 1);
      run("add_cry",  FS_ADD,  32'hFFFF_FFFF, 32'h1,        0, 32'h0,         1,1,0,0,0, 1);
      run("sub_ovf",  FS_SUB,  32'h8000_0000, 32'h1,        0, 32'h7FFF_FFFF, 0,0,1,0,0, 1);
      run("mul_hi",   FS_MUL,  32'h0001_0000, 32'h0001_0000,0, 32'h0,         1,1,0,0,0, 33);
      run("mul_3x5",  FS_MUL,  32'h3,         32'h5,        0, 32'hF,         0,0,0,0,0, 33);
      run("mul_max",  FS_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF,0, 32'h1,         0,1,0,0,0, 33);
      run("divu",     FS_DIVU, 32'd100,       32'd7,        0, 32'd14,        0,0,0,0,0, 33);
      run("remu",     FS_REMU, 32'd100,       32'd7,        0, 32'd2,         0,0,0,0,0, 33);
      run("divu_big", FS_DIVU, 32'hFFFF_FFFF, 32'h1,        0, 32'hFFFF_FFFF, 0,0,0,1,0, 33);
      run("divu_sm",  FS_DIVU, 32'd7,         32'd100,      0, 32'h0,         1,0,0,0,0, 33);
      run("remu_sm",  FS_REMU, 32'd7,         32'd100,      0, 32'd7,         0,0,0,0,0, 33);
      run("divu_z",   FS_DIVU, 32'd5,         32'h0,        0, 32'hFFFF_FFFF, 0,0,1,1,0, 1);
      run("remu_z",   FS_REMU, 32'd9,         32'h0,        0, 32'd9,         0,0,1,0,0, 1);
      run("and",      FS_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,0, 32'hF000_F000, 0,0,0,1,0, 1);
      run("or",       FS_OR,   32'hF0F0_F0F0, 32'hFF00_FF00,0, 32'hFFF0_FFF0, 0,0,0,1,0, 1);
      run("xor",      FS_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,0, 32'h0FF0_0FF0, 0,0,0,0,0, 1);
      run("not",      FS_NOT,  32'hF0F0_F0F0, 32'h0,        0, 32'h0F0F_0F0F, 0,0,0,0,0, 1);
      run("mov_zero", FS_MOV,  32'h0,         32'h1234,     0, 32'h0,         1,0,0,0,0, 1);
      run("jml",      FS_JML,  32'h1234_5678, 32'h0,        0, 32'h1234_5678, 0,0,0,0,0, 1);
      run("lsl1",     FS_LSL,  32'h8000_0001, 32'h0,        1, 32'h2,         0,1,0,0,0, 1);
      run("lsl0",     FS_LSL,  32'hF,         32'h0,        0, 32'hF,         0,0,0,0,0, 1);
      run("lsr1",     FS_LSR,  32'h3,         32'h0,        1, 32'h1,         0,1,0,0,0, 1);
      run("lsr31",    FS_LSR,  32'h8000_0000, 32'h0,        31,32'h1,         0,0,0,0,0, 1);
      run("asr4",     FS_ASR,  32'h7FFF_FFF0, 32'h0,        4, 32'h07FF_FFFF, 0,0,0,0,0, 1);
      run("undef",    5'b11111,32'h1234,      32'h5678,     0, 32'h0,         1,0,0,0,1, 1);

      // Backpressure: result held, new operands refused.
      out_ready = 1'b0;
      expect_r("asr_bp", 32'hC000_0000, 0,1,0,1,0, 1);
      issue(FS_ASR, 32'h8000_0001, 32'h0, 1);
      for (int i = 0; i < 5; i++) begin
         FS = FS_ADD; A = 32'h1; B = 32'h1; in_valid = 1'b1;
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_in_ready",  in_ready,  1'b0);
         chk("bp_F",         F,         32'hC000_0000);
         chk("bp_flags",     {Z, C, V, N, err}, 5'b01010);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      @(negedge clk);
      chk("bp_no_extra", out_valid, 1'b0);

      // Abort a multiply with reset ten cycles in.
      issue(FS_MUL, 32'h3, 32'h5, 0);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready",  in_ready,  1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt_v = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) cnt_v++;
      end
      chk("abort_no_result", cnt_v, 0);
      run("post_abort", FS_ADD, 32'h1, 32'h1, 0, 32'h2, 0,0,0,0,0, 1);

      // Asynchronous reset mid-cycle while a result waits in DONE.
      out_ready = 1'b0;
      expect_r("done_rst", 32'h8000_0000, 0,0,1,1,0, 1);
      issue(FS_ADD, 32'h7FFF_FFFF, 32'h1, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready",  in_ready,  1'b1);
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_F",         F,         '0);
      chk("arst_flags",     {Z, C, V, N, err}, 5'b0);
      @(negedge clk);
      out_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_no_result", out_valid, 1'b0);
      run("post_arst", FS_MUL, 32'd12, 32'd12, 0, 32'd144, 0,0,0,0,0, 33);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/function_unit_mc.md
# function_unit_mc

Parametrised multi-cycle successor to the single-cycle execute-stage function unit. It keeps every existing FS encoding and flag rule and generalises the datapath width. It adds unsigned multiply, unsigned divide/remainder and arithmetic shift right, implemented as iterative sequential operations. Operands enter and results leave through valid/ready handshakes, so the EX stage can stall on long operations.

## Interface
- `WIDTH`, default 32: datapath width in bits, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand bundle valid.
- `in_ready`  out  1: unit can accept an operand bundle.
- `A`  in  WIDTH: first operand.
- `B`  in  WIDTH: second operand.
- `FS`  in  5: function select.
- `SH`  in  SHW: shift amount.
- `out_valid`  out  1: result and flags valid.
- `out_ready`  in  1: consumer accepts the result.
- `F`  out  WIDTH: result.
- `Z`, `C`, `V`, `N`  out  1 each: zero, carry, overflow and negative flags.
- `err`  out  1: FS was undefined.

## Operation
- FS codes are unchanged from the single-cycle unit:
  - 00000 MOV/NOP, 00111 JML: F=A.
  - 00010 ADD, 00101 SUB.
  - 01000 AND, 01010 OR, 01100 XOR, 01110 NOT.
  - 10100 LSL, 11000 LSR.
- New FS codes:
  - 10001 MUL: F = low WIDTH bits of A*B.
  - 10010 DIVU: F = A/B.
  - 10011 REMU: F = A%B.
  - 11100 ASR: arithmetic shift right by SH.
- Flag rules:
  - Z = (F==0), N = F[WIDTH-1], for every defined op.
  - ADD: C = carry out. V = signs of A and B equal and F's sign differs from A.
  - SUB: C = borrow out, i.e. {1'b0,A}-{1'b0,B} bit WIDTH. V = signs of A and B differ and F's sign equals B's.
  - LSL/LSR/ASR: C = last bit shifted out; C=0 when SH=0. V=0.
  - MUL: C = 1 if the high half of the 2·WIDTH product is nonzero. V=0.
  - DIVU/REMU with B=0: F = all ones (DIVU) or A (REMU), V=1, C=0.
  - All other defined ops: C=V=0.
- Undefined FS: F=0, Z=1, C=V=N=0, err=1. The op still completes with latency 1.
- MUL is iterative shift-add, one multiplier bit per cycle.
- DIVU/REMU use restoring division, one quotient bit per cycle.
- Operands are captured at acceptance. Later changes on A, B, FS and SH have no effect.

## Timing
- State machine: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. Accept when `in_valid`. MUL, DIVU and REMU go to BUSY with the iteration counter = WIDTH-1. Every other op goes to DONE.
  - BUSY: `in_ready`=0. The counter decrements each cycle; the move to DONE happens after the cycle in which the counter is 0. That is WIDTH cycles in BUSY.
  - DONE: `out_valid`=1. F, flags and err are held stable until `out_ready`=1. On that edge the state returns to IDLE.
- `in_ready` is 0 in DONE; there is no accept in the same cycle as a result handoff.
- Latency from the accept edge to `out_valid`=1:
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Best-case throughput: one op every 2 cycles, with `out_ready` held high.
- Divide by zero is detected at acceptance and takes the 1-cycle path.
- Reset values of every output: `in_ready`=1, `out_valid`=0, F=0, Z=C=V=N=0, err=0. State is IDLE and the counter is 0.
- Reset asserted mid-BUSY or in DONE discards the operation; no result is ever presented for it.
- `out_ready` asserted while `out_valid`=0 is ignored.

## Structure
- Package `function_unit_pkg` holds:
  - FS localparams: FS_MOV … FS_LSR, FS_MUL, FS_DIVU, FS_REMU, FS_ASR.
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE.
  - Helper function `is_multicycle(FS)`.
- One sub-module, `iter_muldiv`, owns the shift-add/restoring datapath and the counter.
  - Inputs: start, op, A, B.
  - Outputs: done, product low/high, quotient, remainder.
- Single-cycle ops stay combinational in the top level, with a registered result stage.

## Test plan
- Reset state: assert `rst` asynchronously mid-cycle → `in_ready`=1, `out_valid`=0 and all outputs 0 immediately.
- ADD overflow, WIDTH=32: A=7FFFFFFF, B=1 → one cycle after accept, F=80000000, V=1, N=1, C=0, Z=0. Then SUB A=0, B=1 → F=FFFFFFFF, C=1, V=0.
- Multiply latency, WIDTH=32:
  - MUL A=0001_0000, B=0001_0000 → `out_valid` exactly 33 cycles after accept, F=0, Z=1, C=1.
  - MUL 3×5 → F=F (15), C=0.
- Divide:
  - DIVU 100/7 → F=14; REMU 100/7 → F=2; both at latency 33.
  - DIVU x/0 → F=FFFFFFFF, V=1 at latency 1.
- Shifts and backpressure:
  - ASR A=80000001, SH=1 → F=C0000000, C=1.
  - Hold `out_ready`=0 for 5 cycles → F and flags stable, `in_ready`=0, new `in_valid` ignored.
- Error and abort:
  - FS=11111 → err=1, F=0, Z=1.
  - Assert `rst` 10 cycles into a MUL → no `out_valid`; the next op completes normally.
